serial_pattern_gen: RTL and testbench

- Upstream stimulus stage for the serial sequence-detector FSM.
- Takes a parallel pattern word and shifts it out MSB-first on a single-bit line (`dout`), one bit per `BIT_CYCLES` clocks; `dout` connects directly to the detector's `din`.
- Provides a start/busy/done handshake and a hold input, so a controller or bench can stream successive patterns into the detector without hand-timed `din` toggling.

---
 rtl/serial_pattern_gen.sv | 116 +++++++++++
 tb/tb_serial_pattern_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serializes a parallel pattern word MSB-first onto dout, one bit per BIT_CYCLES clocks,
// with a start/busy/done handshake and a hold input that stretches the current bit.
module serial_pattern_gen #(
   parameter int WIDTH      = 18,
   parameter int BIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             hold,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   // The MSB goes straight to dout on load, so only the remaining WIDTH-1 bits are kept.
   logic [WIDTH-2:0] rem_q, rem_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic             dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         dout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               rem_d   = data_in[WIDTH-2:0];
               dout_d  = data_in[WIDTH-1];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               bit_d   = '0;
               cyc_d   = '0;
            end
         end
         S_SHIFT: begin
            if (!hold) begin
               if (cyc_q == LAST_CYC) begin
                  cyc_d = '0;
                  if (bit_q == LAST_BIT) begin
                     state_d = S_DONE;
                     bit_d   = '0;
                     dout_d  = 1'b0;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     bit_d  = bit_q + 1'b1;
                     dout_d = rem_q[WIDTH-2];
                     rem_d  = rem_q << 1;
                  end
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: one instance at one clock per bit, one at four.
module tb_serial_pattern_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0, hold_a = 1'b0;
   logic [17:0] data_a = '0;
   logic        dout_a, valid_a, busy_a, done_a;
   logic        start_b = 1'b0, hold_b = 1'b0;
   logic [17:0] data_b = '0;
   logic        dout_b, valid_b, busy_b, done_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_pattern_gen #(.WIDTH(18), .BIT_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .data_in(data_a), .hold(hold_a),
      .dout(dout_a), .dout_valid(valid_a), .busy(busy_a), .done(done_a)
   );

   serial_pattern_gen #(.WIDTH(18), .BIT_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .data_in(data_b), .hold(hold_b),
      .dout(dout_b), .dout_valid(valid_b), .busy(busy_b), .done(done_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting edge.
   task automatic start_a_pattern(input logic [17:0] w);
      start_a = 1'b1;
      data_a  = w;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   // Walks the 18 bit periods plus the DONE cycle, checking outputs every clock.
   task automatic expect_a(input string name, input logic [17:0] w, input int hold_bit,
                           input int hold_len, input bit poke_start, input bit zero_data);
      int cycles = 0;
      for (int k = 0; k < 18; k++) begin
         int reps = 1 + ((k == hold_bit) ? hold_len : 0);
         for (int r = 0; r < reps; r++) begin
            check($sformatf("%s dout b%0d r%0d", name, k, r), 32'(dout_a), 32'(w[17-k]));
            check($sformatf("%s valid b%0d", name, k), 32'(valid_a), 32'd1);
            check($sformatf("%s busy b%0d", name, k), 32'(busy_a), 32'd1);
            check($sformatf("%s done b%0d", name, k), 32'(done_a), 32'd0);
            hold_a  = (k == hold_bit) && (r < hold_len);
            start_a = poke_start && (k == 9) && (r == 0);
            if (start_a) data_a = 18'h3FFFF;
            if (zero_data && cycles == 0) data_a = 18'h0;
            cycles++;
            @(negedge clk);
         end
      end
      hold_a  = 1'b0;
      start_a = 1'b0;
      check({name, " done pulse"}, 32'(done_a), 32'd1);
      check({name, " done busy"}, 32'(busy_a), 32'd1);
      check({name, " done valid"}, 32'(valid_a), 32'd0);
      check({name, " done dout"}, 32'(dout_a), 32'd0);
      if (poke_start) begin
         start_a = 1'b1;
         data_a  = 18'h3FFFF;
      end
      @(negedge clk);
      start_a = 1'b0;
      check({name, " idle done"}, 32'(done_a), 32'd0);
      check({name, " idle busy"}, 32'(busy_a), 32'd0);
      check({name, " idle valid"}, 32'(valid_a), 32'd0);
      $display("pattern %s word %05h: %0d bit cycles then done", name, w, cycles);
   endtask

   initial begin
      int busy_cnt;
      bit saw_done;

      repeat (3) @(negedge clk);
      check("reset dout", 32'(dout_a), 32'd0);
      check("reset valid", 32'(valid_a), 32'd0);
      check("reset busy", 32'(busy_a), 32'd0);
      check("reset done", 32'(done_a), 32'd0);
      check("reset b busy", 32'(busy_b), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // hold in IDLE does not block acceptance
      hold_a = 1'b1;
      start_a_pattern(18'h32425);
      hold_a = 1'b0;
      expect_a("basic", 18'h32425, -1, 0, 1'b0, 1'b0);

      start_a_pattern(18'h32425);
      expect_a("hold", 18'h32425, 5, 3, 1'b0, 1'b0);

      start_a_pattern(18'h32425);
      expect_a("busy_start", 18'h32425, -1, 0, 1'b1, 1'b0);
      // start offered in the cycle after DONE
      start_a_pattern(18'h2A5C3);
      expect_a("after_done", 18'h2A5C3, -1, 0, 1'b0, 1'b0);

      start_a_pattern(18'h32425);
      expect_a("data_change", 18'h32425, -1, 0, 1'b0, 1'b1);

      // asynchronous reset while bit 9 is on the line
      start_a_pattern(18'h32425);
      repeat (9) @(negedge clk);
      check("pre-reset dout b9", 32'(dout_a), 32'(1'b0));
      check("pre-reset busy", 32'(busy_a), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async rst dout", 32'(dout_a), 32'd0);
      check("async rst valid", 32'(valid_a), 32'd0);
      check("async rst busy", 32'(busy_a), 32'd0);
      check("async rst done", 32'(done_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done_a || busy_a) saw_done = 1'b1;
         @(negedge clk);
      end
      check("no activity after reset", 32'(saw_done), 32'd0);
      $display("pattern reset_mid abandoned at bit 9");
      start_a_pattern(18'h32425);
      expect_a("post_reset", 18'h32425, -1, 0, 1'b0, 1'b0);

      // slow bit rate: 4 clocks per bit
      start_b = 1'b1;
      data_b  = 18'h20001;
      @(negedge clk);
      start_b  = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 72; i++) begin
         check($sformatf("slow dout c%0d", i), 32'(dout_b), (i < 4 || i >= 68) ? 32'd1 : 32'd0);
         if (busy_b) busy_cnt++;
         @(negedge clk);
      end
      check("slow done", 32'(done_b), 32'd1);
      for (int i = 0; i < 30 && busy_b; i++) begin
         busy_cnt++;
         @(negedge clk);
      end
      check("slow busy cycles", 32'(busy_cnt), 32'd73);
      check("slow done cleared", 32'(done_b), 32'd0);
      $display("pattern slow word 20001: busy for %0d cycles", busy_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
